// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit beside the EX ALU.
// Ports:
//   clk, rst (sync, active-low)
//   ex_valid, Op, funct3, funct7, flush : EX-stage instruction info
//   rs1_data, rs2_data                  : forwarded operands
//   stall                               : freeze PC, IF/ID, ID/EX
//   result, result_valid                : registered MDU result
//   busy                                : state is not IDLE
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [6:0]      Op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_MUL = 7'b0000001;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]      r_f3;
  logic            r_neg;
  logic [XLEN-1:0] r_m;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_valid;

  logic            w_is_m;
  logic            w_start;
  logic            w_is_div;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_neg_res;
  logic            w_dz;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_val;

  always_comb begin
    w_is_m = ex_valid
           & (Op == OPC_OP)
           & (funct7 == F7_MUL);
    w_start = rst & w_is_m & ~flush
            & (r_state == S_IDLE);
  end

  // Operand signedness by operation.
  // MUL keeps a signed view; its low
  // word is the same either way.
  always_comb begin
    w_is_div = funct3[2];
    if (w_is_div) begin
      w_sgn_a = ~funct3[0];
      w_sgn_b = ~funct3[0];
    end else begin
      w_sgn_a = (funct3 != F_MULHU);
      w_sgn_b = ~funct3[1];
    end
    w_neg_a = w_sgn_a & rs1_data[XLEN-1];
    w_neg_b = w_sgn_b & rs2_data[XLEN-1];
    w_abs_a = w_neg_a ? -rs1_data : rs1_data;
    w_abs_b = w_neg_b ? -rs2_data : rs2_data;
    // Remainder follows the dividend.
    if (w_is_div && funct3[1])
      w_neg_res = w_neg_a;
    else
      w_neg_res = w_neg_a ^ w_neg_b;
  end

  // Divide-by-zero and signed overflow
  // resolve without iterating.
  always_comb begin
    w_dz = (rs2_data == '0);
    w_ovf = ~funct3[0]
          & (rs1_data == SMIN)
          & (rs2_data == '1);
    w_special = w_is_div & (w_dz | w_ovf);
    if (w_dz)
      w_spec_val = funct3[1] ? rs1_data : '1;
    else
      w_spec_val = funct3[1] ? '0 : SMIN;
  end

  // One shift-add multiply step.
  // r_lo holds the multiplier and
  // shifts right as product bits land.
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mul_hi;
  logic [XLEN-1:0] w_mul_lo;

  always_comb begin
    w_sum = {1'b0, r_hi}
          + (r_lo[0] ? {1'b0, r_m} : '0);
    w_mul_hi = w_sum[XLEN:1];
    w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
  end

  // One restoring divide step.
  // r_hi is the partial remainder,
  // r_lo shifts dividend out and
  // quotient bits in.
  logic [XLEN:0]   w_rsh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_div_hi;
  logic [XLEN-1:0] w_div_lo;

  always_comb begin
    w_rsh = {r_hi, r_lo[XLEN-1]};
    // A set top bit already exceeds
    // any 32-bit divisor.
    w_ge = w_rsh[XLEN]
         | (w_rsh[XLEN-1:0] >= r_m);
    w_diff = w_rsh[XLEN-1:0] - r_m;
    w_div_hi = w_ge ? w_diff
                    : w_rsh[XLEN-1:0];
    w_div_lo = {r_lo[XLEN-2:0], w_ge};
  end

  logic [XLEN-1:0] w_hi_it;
  logic [XLEN-1:0] w_lo_it;

  always_comb begin
    w_hi_it = r_f3[2] ? w_div_hi : w_mul_hi;
    w_lo_it = r_f3[2] ? w_div_lo : w_mul_lo;
  end

  // Sign fix-up and word select on
  // the values of the last iteration.
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_prod   = {w_hi_it, w_lo_it};
    w_prod_s = r_neg ? -w_prod : w_prod;
    w_quo_s  = r_neg ? -w_lo_it : w_lo_it;
    w_rem_s  = r_neg ? -w_hi_it : w_hi_it;
    w_final  = '0;
    unique case (r_f3)
      F_MUL:    w_final = w_prod_s[XLEN-1:0];
      F_MULH,
      F_MULHSU,
      F_MULHU:  w_final = w_prod_s[2*XLEN-1:XLEN];
      F_DIV:    w_final = w_quo_s;
      F_DIVU:   w_final = w_lo_it;
      F_REM:    w_final = w_rem_s;
      F_REMU:   w_final = w_hi_it;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start)
          w_state_nxt = w_special ? S_DONE
                                  : S_BUSY;
      end
      S_BUSY: begin
        if (flush)
          w_state_nxt = S_IDLE;
        else if (r_cnt == 5'd0)
          w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_DONE);
      if (w_start) begin
        r_f3  <= funct3;
        r_neg <= w_neg_res;
        r_hi  <= '0;
        r_cnt <= 5'd31;
        if (w_is_div) begin
          r_m  <= w_abs_b;
          r_lo <= w_abs_a;
        end else begin
          r_m  <= w_abs_a;
          r_lo <= w_abs_b;
        end
        if (w_special)
          r_result <= w_spec_val;
      end else if (r_state == S_BUSY
                   && !flush) begin
        r_hi <= w_hi_it;
        r_lo <= w_lo_it;
        if (r_cnt == 5'd0)
          r_result <= w_final;
        else
          r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  // Stall is combinational so the start
  // cycle itself holds the pipeline.
  assign stall = rst & ~flush
               & (w_start | (r_state == S_BUSY));
  assign result       = r_result;
  assign result_valid = r_valid;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: randomized + directed bench
// for mdu_sequencer with a behavioural model.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        flush;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .Op(Op),
    .funct3(funct3),
    .funct7(funct7),
    .flush(flush),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .stall(stall),
    .result(result),
    .result_valid(result_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(
    input logic [2:0] f,
    input logic [31:0] a,
    input logic [31:0] b);
    longint p;
    logic [63:0] u;
    int ia;
    int ib;
    ia = a;
    ib = b;
    ref_op = '0;
    case (f)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        ref_op = p[31:0];
      end
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        ref_op = p[63:32];
      end
      3'd2: begin
        p = longint'($signed(a)) * longint'({32'b0, b});
        ref_op = p[63:32];
      end
      3'd3: begin
        u = {32'b0, a} * {32'b0, b};
        ref_op = u[63:32];
      end
      3'd4: begin
        if (b == 0) ref_op = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          ref_op = 32'h80000000;
        else ref_op = ia / ib;
      end
      3'd5: ref_op = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) ref_op = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          ref_op = 0;
        else ref_op = ia % ib;
      end
      default: ref_op = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: m_act = an op is in flight,
  // m_cnt = cycles left until its result cycle.
  bit          m_act = 0;
  int          m_cnt = 0;
  logic [31:0] m_res = 0;
  logic [31:0] m_pend = 0;

  initial begin
    bit is_m;
    bit st;
    bit spec;
    bit n_act;
    int n_cnt;
    logic [31:0] n_res;
    forever begin
      @(negedge clk); #1;
      is_m = ex_valid && Op == 7'h33 && funct7 == 7'h01;
      st = rst && is_m && !m_act && !flush;
      chk("stall", stall,
          rst && !flush && (st || (m_act && m_cnt > 0)));
      n_act = m_act;
      n_cnt = m_cnt;
      n_res = m_res;
      if (!rst) begin
        n_act = 0;
        n_cnt = 0;
        n_res = 0;
      end else if (st) begin
        spec = funct3[2] && (rs2_data == 0 ||
               (!funct3[0] && rs1_data == 32'h80000000
                && rs2_data == 32'hFFFFFFFF));
        m_pend = ref_op(funct3, rs1_data, rs2_data);
        n_act = 1;
        n_cnt = spec ? 0 : 32;
        if (spec) n_res = m_pend;
      end else if (m_act) begin
        if (flush || m_cnt == 0) n_act = 0;
        else begin
          n_cnt = m_cnt - 1;
          if (n_cnt == 0) n_res = m_pend;
        end
      end
      @(posedge clk); #1;
      m_act = n_act;
      m_cnt = n_cnt;
      m_res = n_res;
      chk("result_valid", result_valid, m_act && m_cnt == 0);
      chk("result", result, m_res);
      chk("busy", busy, m_act);
    end
  end

  task automatic run_op(input string nm,
                        input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int lat);
    int n;
    int sc;
    n = 0;
    sc = 0;
    @(negedge clk);
    ex_valid = 1; Op = 7'h33; funct7 = 7'h01;
    funct3 = f; rs1_data = a; rs2_data = b; flush = 0;
    forever begin
      #2;
      if (stall) sc++;
      @(posedge clk); #1;
      n++;
      if (result_valid || n >= 60) break;
      @(negedge clk);
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " value"}, result, exp);
    chk({nm, " stall cycles"}, sc, lat);
    @(negedge clk);
    ex_valid = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 0;
      1: pick = 1;
      2: pick = 32'hFFFFFFFF;
      3: pick = 32'h80000000;
      4: pick = 32'h7FFFFFFF;
      5: pick = $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int np;
    int c1;
    int c2;
    int sc;
    logic [31:0] v1;
    logic [31:0] v2;
    rst = 0; ex_valid = 0; Op = 0; funct3 = 0;
    funct7 = 0; flush = 0; rs1_data = 0; rs2_data = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset stall", stall, 0);
    chk("reset result", result, 0);
    chk("reset valid", result_valid, 0);
    chk("reset busy", busy, 0);
    rst = 1;

    chk("ref mul", ref_op(0, 7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("ref mulh", ref_op(1, 7, 32'hFFFFFFFD), 32'hFFFFFFFF);
    chk("ref mulhu", ref_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("ref mulhsu", ref_op(2, 32'hFFFFFFFF, 2), 32'hFFFFFFFF);
    chk("ref div", ref_op(4, 32'hFFFFFFF9, 2), 32'hFFFFFFFD);
    chk("ref rem", ref_op(6, 32'hFFFFFFF9, 2), 32'hFFFFFFFF);
    chk("ref divu", ref_op(5, 100, 7), 14);
    chk("ref remu", ref_op(7, 100, 7), 2);
    chk("ref div0", ref_op(4, 5, 0), 32'hFFFFFFFF);
    chk("ref remu0", ref_op(7, 5, 0), 5);
    chk("ref ovf", ref_op(4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("ref rovf", ref_op(6, 32'h80000000, 32'hFFFFFFFF), 0);

    run_op("MUL", 0, 7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("MULH", 1, 7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_op("MULHU", 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("MULHSU", 2, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 33);
    run_op("DIV", 4, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 33);
    run_op("REM", 6, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 33);
    run_op("DIVU", 5, 100, 7, 14, 33);
    run_op("REMU", 7, 100, 7, 2, 33);
    run_op("DIV0", 4, 5, 0, 32'hFFFFFFFF, 1);
    run_op("REMU0", 7, 5, 0, 5, 1);
    run_op("DIVOVF", 4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REMOVF", 6, 32'h80000000, 32'hFFFFFFFF, 0, 1);

    // Flush at T10 of a DIV.
    @(negedge clk);
    ex_valid = 1; Op = 7'h33; funct7 = 1; funct3 = 4;
    rs1_data = 1000; rs2_data = 7;
    repeat (10) @(negedge clk);
    flush = 1; ex_valid = 0;
    #2;
    chk("flush stall", stall, 0);
    @(negedge clk);
    flush = 0;
    chk("flush busy", busy, 0);
    np = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid) np++;
    end
    chk("flush no pulse", np, 0);

    // Reset at T20 of a MUL.
    @(negedge clk);
    ex_valid = 1; funct3 = 0; rs1_data = 12345; rs2_data = 678;
    repeat (20) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("rst result", result, 0);
    chk("rst valid", result_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst stall", stall, 0);
    @(negedge clk);
    rst = 1; ex_valid = 0;

    // Back-to-back MULs with ex_valid held.
    @(negedge clk);
    ex_valid = 1; funct3 = 0; rs1_data = 3; rs2_data = 5;
    np = 0; c1 = -1; c2 = -1; v1 = 0; v2 = 0;
    for (int i = 0; i < 68; i++) begin
      if (i >= 1 && i <= 33) begin
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      if (i == 34) begin
        rs1_data = 9;
        rs2_data = 11;
      end
      @(posedge clk); #1;
      if (result_valid) begin
        np++;
        if (np == 1) begin c1 = i + 1; v1 = result; end
        else begin c2 = i + 1; v2 = result; end
      end
      @(negedge clk);
    end
    ex_valid = 0;
    chk("b2b pulses", np, 2);
    chk("b2b first cycle", c1, 33);
    chk("b2b gap", c2 - c1, 34);
    chk("b2b first value", v1, 15);
    chk("b2b second value", v2, 99);

    // Non-M instructions.
    sc = 0;
    @(negedge clk);
    ex_valid = 1; Op = 7'h33; funct7 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin Op = 7'h13; funct7 = 1; end
      #2;
      if (stall) sc++;
      @(negedge clk);
    end
    chk("non-M stall", sc, 0);
    ex_valid = 0; Op = 7'h33; funct7 = 1;

    // Random traffic.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 79) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      Op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h33;
      funct7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h01;
      funct3 = 3'($urandom);
      rs1_data = pick();
      rs2_data = pick();
    end
    @(negedge clk);
    rst = 1; flush = 0; ex_valid = 0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
